// File: rtl/memwrite_scoreboard.sv
// Scoreboard for the data-memory write port: checks observed (dataadr, writedata)
// writes against a loaded table of K expected pairs, with ordered/unordered matching and a watchdog.
module memwrite_scoreboard #(
   parameter int N       = 16,
   parameter int A       = 16,
   parameter int K       = 4,
   parameter int TW      = 16,
   parameter bit ORDERED = 1'b1,
   localparam int IW     = (K > 1) ? $clog2(K) : 1,
   localparam int CW     = $clog2(K + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [IW-1:0] load_idx,
   input  logic [A-1:0]  load_addr,
   input  logic [N-1:0]  load_data,
   input  logic [TW-1:0] timeout,
   input  logic          start,
   input  logic          memwrite,
   input  logic [A-1:0]  dataadr,
   input  logic [N-1:0]  writedata,
   output logic          done,
   output logic          pass,
   output logic [1:0]    fail_code,
   output logic [CW-1:0] match_count,
   output logic [TW-1:0] cycles,
   output logic [IW-1:0] fail_index,
   output logic [1:0]    state_dbg
);

   // load_en, start and memwrite are single-cycle strobes sampled on the rising
   // edge with no backpressure; a strobe is acted on in the cycle it is high.
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

   state_t        state_q, state_d;
   logic [A-1:0]  tbl_addr [K];
   logic [N-1:0]  tbl_data [K];
   logic [K-1:0]  hit_q, hit_d;
   logic [CW-1:0] mc_q, mc_d;
   logic [TW-1:0] cyc_q, cyc_d, cyc_inc, tmo_q, tmo_d;
   logic [1:0]    code_q, code_d;
   logic [IW-1:0] fidx_q, fidx_d;

   logic          load_ok;
   logic [IW-1:0] ptr;
   logic          ev_hit, ev_fail;
   logic [IW-1:0] ev_hit_idx, ev_fail_idx;
   logic [1:0]    ev_fail_code;

   assign load_ok = load_en && (state_q != S_ARMED) && (int'(load_idx) < K);
   assign ptr     = IW'(mc_q);
   assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + TW'(1);

   // Classify the current write against the table (valid only while ARMED).
   always_comb begin
      logic          dm, am;
      logic [IW-1:0] dm_idx, am_idx;
      ev_hit       = 1'b0;
      ev_hit_idx   = '0;
      ev_fail      = 1'b0;
      ev_fail_idx  = '0;
      ev_fail_code = 2'b00;
      dm           = 1'b0;
      am           = 1'b0;
      dm_idx       = '0;
      am_idx       = '0;
      if (ORDERED) begin
         for (int j = K - 1; j >= 0; j--) begin
            if (j > int'(ptr) && !hit_q[j] && tbl_addr[j] == dataadr) begin
               am     = 1'b1;
               am_idx = IW'(j);
            end
         end
         if (tbl_addr[ptr] == dataadr) begin
            if (tbl_data[ptr] == writedata) begin
               ev_hit     = 1'b1;
               ev_hit_idx = ptr;
            end else begin
               ev_fail      = 1'b1;
               ev_fail_code = 2'b01;
               ev_fail_idx  = ptr;
            end
         end else if (am) begin
            ev_fail      = 1'b1;
            ev_fail_code = 2'b11;
            ev_fail_idx  = am_idx;
         end
      end else begin
         // Downward scan so the lowest matching index is the one that sticks.
         for (int j = K - 1; j >= 0; j--) begin
            if (!hit_q[j] && tbl_addr[j] == dataadr) begin
               am     = 1'b1;
               am_idx = IW'(j);
               if (tbl_data[j] == writedata) begin
                  dm     = 1'b1;
                  dm_idx = IW'(j);
               end
            end
         end
         if (dm) begin
            ev_hit     = 1'b1;
            ev_hit_idx = dm_idx;
         end else if (am) begin
            ev_fail      = 1'b1;
            ev_fail_code = 2'b01;
            ev_fail_idx  = am_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      hit_d   = hit_q;
      mc_d    = mc_q;
      cyc_d   = cyc_q;
      tmo_d   = tmo_q;
      code_d  = code_q;
      fidx_d  = fidx_q;
      if (start) begin
         state_d = S_ARMED;
         hit_d   = '0;
         mc_d    = '0;
         cyc_d   = '0;
         code_d  = 2'b00;
         fidx_d  = '0;
         tmo_d   = timeout;
      end else begin
         case (state_q)
            S_ARMED: begin
               cyc_d = cyc_inc;
               if (memwrite && ev_fail) begin
                  state_d = S_FAIL;
                  code_d  = ev_fail_code;
                  fidx_d  = ev_fail_idx;
               end else if (memwrite && ev_hit) begin
                  hit_d[ev_hit_idx] = 1'b1;
                  mc_d              = mc_q + CW'(1);
                  if (mc_q == CW'(K - 1)) state_d = S_PASS;
               end
               // A final match on the timeout edge has already moved us to PASS.
               if (state_d == S_ARMED && tmo_q != '0 && cyc_inc == tmo_q) begin
                  state_d = S_FAIL;
                  code_d  = 2'b10;
               end
            end
            S_PASS, S_FAIL: if (load_en) state_d = S_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         hit_q   <= '0;
         mc_q    <= '0;
         cyc_q   <= '0;
         tmo_q   <= '0;
         code_q  <= 2'b00;
         fidx_q  <= '0;
         for (int j = 0; j < K; j++) begin
            tbl_addr[j] <= '0;
            tbl_data[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         mc_q    <= mc_d;
         cyc_q   <= cyc_d;
         tmo_q   <= tmo_d;
         code_q  <= code_d;
         fidx_q  <= fidx_d;
         if (load_ok) begin
            tbl_addr[load_idx] <= load_addr;
            tbl_data[load_idx] <= load_data;
         end
      end
   end

   assign done        = (state_q == S_PASS) || (state_q == S_FAIL);
   assign pass        = (state_q == S_PASS);
   assign fail_code   = code_q;
   assign match_count = mc_q;
   assign cycles      = cyc_q;
   assign fail_index  = fidx_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_memwrite_scoreboard.sv
// Directed bench: an ordered and an unordered scoreboard share one stimulus stream
// and are checked against hand-computed outcomes.
module tb_memwrite_scoreboard;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_en = 1'b0;
   logic [1:0]  load_idx = '0;
   logic [15:0] load_addr = '0;
   logic [15:0] load_data = '0;
   logic [15:0] timeout = '0;
   logic        start = 1'b0;
   logic        memwrite = 1'b0;
   logic [15:0] dataadr = '0;
   logic [15:0] writedata = '0;

   logic        o_done, o_pass, a_done, a_pass;
   logic [1:0]  o_code, a_code, o_fidx, a_fidx, o_st, a_st;
   logic [2:0]  o_mc, a_mc;
   logic [15:0] o_cyc, a_cyc;

   int n_vec  = 0;
   int n_miss = 0;

   logic [15:0] t_addr [4] = '{16'd64, 16'd68, 16'd72, 16'd76};
   logic [15:0] t_data [4] = '{16'h0096, 16'h0007, 16'h1234, 16'hFFFF};

   memwrite_scoreboard #(.N(16), .A(16), .K(4), .TW(16), .ORDERED(1'b1)) u_ord (
      .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
      .load_addr(load_addr), .load_data(load_data), .timeout(timeout), .start(start),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .done(o_done), .pass(o_pass), .fail_code(o_code), .match_count(o_mc),
      .cycles(o_cyc), .fail_index(o_fidx), .state_dbg(o_st));

   memwrite_scoreboard #(.N(16), .A(16), .K(4), .TW(16), .ORDERED(1'b0)) u_any (
      .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
      .load_addr(load_addr), .load_data(load_data), .timeout(timeout), .start(start),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .done(a_done), .pass(a_pass), .fail_code(a_code), .match_count(a_mc),
      .cycles(a_cyc), .fail_index(a_fidx), .state_dbg(a_st));

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drivers: inputs change 1 ns after the rising edge, outputs are read there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_table();
      for (int i = 0; i < 4; i++) begin
         load_en   = 1'b1;
         load_idx  = 2'(i);
         load_addr = t_addr[i];
         load_data = t_data[i];
         tick();
      end
      load_en = 1'b0;
   endtask

   task automatic arm(input logic [15:0] tmo);
      start   = 1'b1;
      timeout = tmo;
      tick();
      start = 1'b0;
   endtask

   task automatic wr(input logic [15:0] adr, input logic [15:0] dat);
      memwrite  = 1'b1;
      dataadr   = adr;
      writedata = dat;
      tick();
      memwrite = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic ord, input logic [1:0] done_pass,
                               input logic [1:0] code, input logic [2:0] mc,
                               input logic [15:0] cyc);
      if (ord) begin
         check({tag, " ord done/pass"}, {o_done, o_pass}, done_pass);
         check({tag, " ord code"}, o_code, code);
         check({tag, " ord match_count"}, o_mc, mc);
         check({tag, " ord cycles"}, o_cyc, cyc);
      end else begin
         check({tag, " any done/pass"}, {a_done, a_pass}, done_pass);
         check({tag, " any code"}, a_code, code);
         check({tag, " any match_count"}, a_mc, mc);
         check({tag, " any cycles"}, a_cyc, cyc);
      end
   endtask

   initial begin
      #2;
      check_result("reset", 1'b1, 2'b00, 2'b00, 3'd0, 16'd0);
      check("reset ord state", o_st, 2'd0);
      reset = 1'b1;
      tick();
      load_table();

      // In-order writes on cycles 5/10/15/20: both variants pass at cycles=20.
      arm(16'd100);
      for (int i = 0; i < 4; i++) begin
         idle(4);
         wr(t_addr[i], t_data[i]);
      end
      check_result("inorder", 1'b1, 2'b11, 2'b00, 3'd4, 16'd20);
      check_result("inorder", 1'b0, 2'b11, 2'b00, 3'd4, 16'd20);

      // Entry 1 written first: order violation for ordered, a plain hit otherwise.
      arm(16'd100);
      wr(16'd68, 16'h0007);
      check_result("early68", 1'b1, 2'b10, 2'b11, 3'd0, 16'd1);
      check("early68 ord fail_index", o_fidx, 2'd1);
      check("early68 any match_count", a_mc, 3'd1);
      check("early68 any done", a_done, 1'b0);

      // Reverse-ish order with writes to untracked address 100 in between.
      arm(16'd100);
      wr(16'd76, 16'hFFFF);
      wr(16'd100, 16'hAAAA);
      check("anyorder partial mc", a_mc, 3'd1);
      check("anyorder partial done", a_done, 1'b0);
      check("anyorder ord code", o_code, 2'b11);
      check("anyorder ord fail_index", o_fidx, 2'd3);
      wr(16'd64, 16'h0096);
      wr(16'd100, 16'h5555);
      wr(16'd72, 16'h1234);
      wr(16'd68, 16'h0007);
      check_result("anyorder", 1'b0, 2'b11, 2'b00, 3'd4, 16'd6);

      // Wrong data on pending entry 0: data mismatch visible the cycle after the write.
      arm(16'd100);
      check("baddata pre done", o_done, 1'b0);
      wr(16'd64, 16'h0095);
      check_result("baddata", 1'b1, 2'b10, 2'b01, 3'd0, 16'd1);
      check_result("baddata", 1'b0, 2'b10, 2'b01, 3'd0, 16'd1);
      check("baddata ord fail_index", o_fidx, 2'd0);
      check("baddata any fail_index", a_fidx, 2'd0);

      // Watchdog: two matches, timeout 8.
      arm(16'd8);
      wr(16'd64, 16'h0096);
      wr(16'd68, 16'h0007);
      idle(5);
      check_result("tmo c7", 1'b1, 2'b00, 2'b00, 3'd2, 16'd7);
      tick();
      check_result("tmo", 1'b1, 2'b10, 2'b10, 3'd2, 16'd8);
      check_result("tmo", 1'b0, 2'b10, 2'b10, 3'd2, 16'd8);
      tick();
      check("tmo frozen cycles", o_cyc, 16'd8);

      // Final match lands on the timeout edge: pass wins.
      arm(16'd8);
      for (int i = 0; i < 3; i++) wr(t_addr[i], t_data[i]);
      idle(4);
      check("race c7 mc", o_mc, 3'd3);
      wr(16'd76, 16'hFFFF);
      check_result("race", 1'b1, 2'b11, 2'b00, 3'd4, 16'd8);
      check_result("race", 1'b0, 2'b11, 2'b00, 3'd4, 16'd8);

      // A load in PASS returns to IDLE.
      load_table();
      check("pass->idle ord state", o_st, 2'd0);
      check("pass->idle any done", a_done, 1'b0);

      // Asynchronous reset mid-check after two matches.
      arm(16'd100);
      wr(16'd64, 16'h0096);
      wr(16'd68, 16'h0007);
      check("prereset mc", o_mc, 3'd2);
      reset = 1'b0;
      #1;
      check_result("midreset", 1'b1, 2'b00, 2'b00, 3'd0, 16'd0);
      check_result("midreset", 1'b0, 2'b00, 2'b00, 3'd0, 16'd0);
      check("midreset ord state", o_st, 2'd0);
      reset = 1'b1;
      tick();
      load_table();
      arm(16'd100);
      for (int i = 0; i < 4; i++) wr(t_addr[i], t_data[i]);
      check_result("postreset", 1'b1, 2'b11, 2'b00, 3'd4, 16'd4);
      check_result("postreset", 1'b0, 2'b11, 2'b00, 3'd4, 16'd4);

      // report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
